// File: rtl/pid_speed_ctrl_if.sv
// Sample/command bundle between the encoder RPM stage,
// the speed PID and the PWM generator.
interface pid_speed_ctrl_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                         pid_en_i;
    logic                         rpm_valid_i;
    logic signed [DATA_WIDTH-1:0] rpm_data_i;
    logic signed [DATA_WIDTH-1:0] target_rpm_i;
    logic        [15:0]           kp_i;
    logic        [15:0]           ki_i;
    logic        [15:0]           kd_i;
    logic                         busy_o;
    logic                         duty_valid_o;
    logic signed [DATA_WIDTH-1:0] duty_o;
    logic                         overrun_o;

    modport master (
        output pid_en_i, rpm_valid_i, rpm_data_i,
        output target_rpm_i, kp_i, ki_i, kd_i,
        input  busy_o, duty_valid_o, duty_o, overrun_o
    );

    modport slave (
        input  pid_en_i, rpm_valid_i, rpm_data_i,
        input  target_rpm_i, kp_i, ki_i, kd_i,
        output busy_o, duty_valid_o, duty_o, overrun_o
    );
endinterface

// File: rtl/pid_speed_ctrl.sv
// Speed PID: err -> clamped integrator / first difference ->
// Q8.8 gain products -> shifted, saturated signed duty command.
module pid_speed_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int INTEG_LIMIT = 20000,
    parameter int OUT_MAX     = 1000
) (
    input logic             clk,
    input logic             rst,
    pid_speed_ctrl_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int IW = DW + 2;
    localparam int PW = DW + 18;
    localparam int SW = PW + 2;

    localparam logic signed [DW:0] E_MAX =
        $signed({2'b00, {(DW-1){1'b1}}});
    localparam logic signed [DW:0] E_MIN =
        $signed({2'b11, {(DW-1){1'b0}}});
    localparam logic signed [IW-1:0] I_MAX = IW'(INTEG_LIMIT);
    localparam logic signed [IW-1:0] I_MIN = IW'(-INTEG_LIMIT);
    localparam logic signed [DW-1:0] I_MAX_D = DW'(INTEG_LIMIT);
    localparam logic signed [DW-1:0] I_MIN_D = DW'(-INTEG_LIMIT);
    localparam logic signed [SW-1:0] O_MAX = SW'(OUT_MAX);
    localparam logic signed [SW-1:0] O_MIN = SW'(-OUT_MAX);
    localparam logic signed [DW-1:0] O_MAX_D = DW'(OUT_MAX);
    localparam logic signed [DW-1:0] O_MIN_D = DW'(-OUT_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_MUL, S_SUM, S_OUT
    } state_t;

    state_t state, state_nxt;

    logic en, accept, busy, duty_valid, overrun;
    logic signed [DW-1:0] rpm_r, tgt_r;
    logic        [15:0]   kp_r, ki_r, kd_r;
    logic signed [DW-1:0] integ, integ_nxt, err_prev, e;
    logic signed [DW:0]   e17, d_nxt, d_r;
    logic signed [IW-1:0] isum;
    logic signed [PW-1:0] p_r, i_r, dd_r;
    logic signed [SW-1:0] sum, sh;
    logic signed [DW-1:0] duty, duty_nxt;

    assign en = bus.pid_en_i;

    always_ff @(posedge clk) begin
        if (rst || !en) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (bus.rpm_valid_i) state_nxt = S_ERR;
            S_ERR:  state_nxt = S_MUL;
            S_MUL:  state_nxt = S_SUM;
            S_SUM:  state_nxt = S_OUT;
            S_OUT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        duty_valid = (state == S_OUT) && en;
        accept     = (state == S_IDLE) && en && bus.rpm_valid_i;
    end

    always_comb begin
        e17 = {tgt_r[DW-1], tgt_r} - {rpm_r[DW-1], rpm_r};
        if (e17 > E_MAX)      e = {1'b0, {(DW-1){1'b1}}};
        else if (e17 < E_MIN) e = {1'b1, {(DW-1){1'b0}}};
        else                  e = e17[DW-1:0];
        isum = IW'(integ) + IW'(e);
        if (isum > I_MAX)      integ_nxt = I_MAX_D;
        else if (isum < I_MIN) integ_nxt = I_MIN_D;
        else                   integ_nxt = isum[DW-1:0];
        d_nxt = (DW+1)'(e) - (DW+1)'(err_prev);
    end

    // floor division by 2^FRAC_BITS, then symmetric clamp
    always_comb begin
        sum = SW'(p_r) + SW'(i_r) + SW'(dd_r);
        sh  = sum >>> FRAC_BITS;
        if (sh > O_MAX)      duty_nxt = O_MAX_D;
        else if (sh < O_MIN) duty_nxt = O_MIN_D;
        else                 duty_nxt = sh[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            rpm_r    <= '0;
            tgt_r    <= '0;
            kp_r     <= '0;
            ki_r     <= '0;
            kd_r     <= '0;
            integ    <= '0;
            err_prev <= '0;
            d_r      <= '0;
            p_r      <= '0;
            i_r      <= '0;
            dd_r     <= '0;
            duty     <= '0;
        end else begin
            unique case (1'b1)
                accept: begin
                    rpm_r <= bus.rpm_data_i;
                    tgt_r <= bus.target_rpm_i;
                    kp_r  <= bus.kp_i;
                    ki_r  <= bus.ki_i;
                    kd_r  <= bus.kd_i;
                end
                state == S_ERR: begin
                    integ    <= integ_nxt;
                    err_prev <= e;
                    d_r      <= d_nxt;
                end
                // err_prev already holds this sample's error here
                state == S_MUL: begin
                    p_r  <= PW'(err_prev) * PW'($signed({1'b0, kp_r}));
                    i_r  <= PW'(integ) * PW'($signed({1'b0, ki_r}));
                    dd_r <= PW'(d_r) * PW'($signed({1'b0, kd_r}));
                end
                state == S_SUM: duty <= duty_nxt;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                                  overrun <= 1'b0;
        else if (en && bus.rpm_valid_i && busy)   overrun <= 1'b1;
    end

    assign bus.busy_o       = busy;
    assign bus.duty_valid_o = duty_valid;
    assign bus.duty_o       = duty;
    assign bus.overrun_o    = overrun;
endmodule

// File: tb/tb_pid_speed_ctrl.sv
// Scoreboard bench for pid_speed_ctrl: a reference model queues
// the expected duty per accepted strobe; a monitor pops on duty_valid_o.
module tb_pid_speed_ctrl;
    logic clk = 1'b0;
    logic rst;

    pid_speed_ctrl_if #(.DATA_WIDTH(16)) bus ();

    pid_speed_ctrl #(
        .DATA_WIDTH(16),
        .FRAC_BITS(8),
        .INTEG_LIMIT(20000),
        .OUT_MAX(1000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #50 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint m_integ = 0;
    longint m_eprev = 0;
    int     exp_q[$];

    function automatic int model(input int t, input int r,
                                 input int kp, input int ki,
                                 input int kd);
        longint e, d, s;
        e = longint'(t) - longint'(r);
        if (e > 32767) e = 32767;
        if (e < -32768) e = -32768;
        m_integ = m_integ + e;
        if (m_integ > 20000) m_integ = 20000;
        if (m_integ < -20000) m_integ = -20000;
        d = e - m_eprev;
        m_eprev = e;
        s = kp * e + ki * m_integ + kd * d;
        s = s >>> 8;
        if (s > 1000) s = 1000;
        if (s < -1000) s = -1000;
        return int'(s);
    endfunction

    always @(negedge clk) begin
        int x;
        if (bus.duty_valid_o === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_duty_valid got duty=%0d need none",
                         bus.duty_o);
            end else begin
                x = exp_q.pop_front();
                if (bus.duty_o !== x[15:0]) begin
                    miscompares++;
                    $display("FAIL duty got %0d need %0d", bus.duty_o, x);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic drive(input int t, input int r, input int kp,
                         input int ki, input int kd);
        bus.target_rpm_i = t[15:0];
        bus.rpm_data_i   = r[15:0];
        bus.kp_i         = kp[15:0];
        bus.ki_i         = ki[15:0];
        bus.kd_i         = kd[15:0];
        bus.rpm_valid_i  = 1'b1;
    endtask

    task automatic sample(input int t, input int r, input int kp,
                          input int ki, input int kd);
        int n;
        @(negedge clk);
        drive(t, r, kp, ki, kd);
        exp_q.push_back(model(t, r, kp, ki, kd));
        @(negedge clk);
        bus.rpm_valid_i = 1'b0;
        n = 1;
        while (bus.duty_valid_o !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n != 4) begin
            miscompares++;
            $display("FAIL latency got %0d cycles need 4", n);
        end
    endtask

    task automatic clean();
        @(negedge clk);
        bus.pid_en_i = 1'b0;
        m_integ = 0;
        m_eprev = 0;
        @(negedge clk);
        bus.pid_en_i = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_integ = 0;
        m_eprev = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic count_valid(output int cnt);
        cnt = 0;
        repeat (8) begin
            if (bus.duty_valid_o === 1'b1) cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.pid_en_i = 1'b0;
        bus.rpm_valid_i = 1'b0;
        drive(0, 0, 0, 0, 0);
        bus.rpm_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_busy got %b need 0", bus.busy_o);
        end
        vectors++;
        if (bus.duty_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_valid got %b need 0", bus.duty_valid_o);
        end
        vectors++;
        if (bus.duty_o !== 16'sd0) begin
            miscompares++;
            $display("FAIL rst_duty got %0d need 0", bus.duty_o);
        end
        vectors++;
        if (bus.overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_overrun got %b need 0", bus.overrun_o);
        end
        rst = 1'b0;
        bus.pid_en_i = 1'b1;
    endtask

    task automatic test_prop();
        sample(1000, 400, 'h0100, 0, 0);
        vectors++;
        if (bus.duty_o !== 16'sd600) begin
            miscompares++;
            $display("FAIL t1_duty got %0d need 600", bus.duty_o);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (bus.duty_o !== 16'sd600 || bus.duty_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_hold got %0d/%b need 600/0",
                     bus.duty_o, bus.duty_valid_o);
        end
    endtask

    task automatic test_integ();
        clean();
        for (int i = 0; i < 3; i++) sample(100, 0, 0, 'h0100, 0);
        vectors++;
        if (bus.duty_o !== 16'sd300) begin
            miscompares++;
            $display("FAIL t2_integ got %0d need 300", bus.duty_o);
        end
        clean();
        for (int i = 0; i < 70; i++) sample(100, 0, 0, 'h1000, 0);
        vectors++;
        if (bus.duty_o !== 16'sd1000) begin
            miscompares++;
            $display("FAIL t2_sat got %0d need 1000", bus.duty_o);
        end
        clean();
        sample(32767, -32768, 0, 1, 0);
        sample(32767, -32768, 0, 1, 0);
        vectors++;
        if (bus.duty_o !== 16'sd78) begin
            miscompares++;
            $display("FAIL t2_clamp_pos got %0d need 78", bus.duty_o);
        end
        sample(-32768, 32767, 0, 1, 0);
        vectors++;
        if (bus.duty_o !== -16'sd50) begin
            miscompares++;
            $display("FAIL t2_floor got %0d need -50", bus.duty_o);
        end
        sample(-32768, 32767, 0, 1, 0);
        vectors++;
        if (bus.duty_o !== -16'sd79) begin
            miscompares++;
            $display("FAIL t2_clamp_neg got %0d need -79", bus.duty_o);
        end
    endtask

    task automatic test_deriv();
        clean();
        sample(0, -50, 0, 0, 'h0100);
        vectors++;
        if (bus.duty_o !== 16'sd50) begin
            miscompares++;
            $display("FAIL t3_d1 got %0d need 50", bus.duty_o);
        end
        sample(0, -80, 0, 0, 'h0100);
        vectors++;
        if (bus.duty_o !== 16'sd30) begin
            miscompares++;
            $display("FAIL t3_d2 got %0d need 30", bus.duty_o);
        end
    endtask

    task automatic test_sat();
        clean();
        sample(-32768, 32767, 'h7FFF, 0, 0);
        vectors++;
        if (bus.duty_o !== -16'sd1000) begin
            miscompares++;
            $display("FAIL t4_neg got %0d need -1000", bus.duty_o);
        end
        sample(32767, -32768, 'h7FFF, 0, 0);
        vectors++;
        if (bus.duty_o !== 16'sd1000) begin
            miscompares++;
            $display("FAIL t4_pos got %0d need 1000", bus.duty_o);
        end
    endtask

    task automatic test_out_cycle();
        int cnt;
        do_reset();
        sample(500, 0, 'h0100, 0, 0);
        drive(100, 0, 'h0100, 0, 0);
        @(negedge clk);
        bus.rpm_valid_i = 1'b0;
        count_valid(cnt);
        vectors++;
        if (cnt != 0 || bus.overrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL out_cycle_drop got %0d/%b need 0/1",
                     cnt, bus.overrun_o);
        end
    endtask

    task automatic test_overrun();
        int cnt;
        do_reset();
        vectors++;
        if (bus.overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_pre got %b need 0", bus.overrun_o);
        end
        @(negedge clk);
        drive(300, 0, 'h0100, 0, 0);
        exp_q.push_back(model(300, 0, 'h0100, 0, 0));
        @(negedge clk);
        bus.rpm_valid_i = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_busy got %b need 1", bus.busy_o);
        end
        drive(900, 0, 'h0100, 0, 0);
        @(negedge clk);
        bus.rpm_valid_i = 1'b0;
        count_valid(cnt);
        vectors++;
        if (cnt != 1 || bus.overrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL t5_overrun got %0d/%b need 1/1",
                     cnt, bus.overrun_o);
        end
        vectors++;
        if (bus.duty_o !== 16'sd300) begin
            miscompares++;
            $display("FAIL t5_duty got %0d need 300", bus.duty_o);
        end
    endtask

    task automatic test_back_to_back();
        int t, r;
        clean();
        for (int i = 0; i < 8; i++) begin
            t = int'($urandom_range(4000)) - 2000;
            r = int'($urandom_range(4000)) - 2000;
            sample(t, r, int'($urandom_range(1024)),
                   int'($urandom_range(64)),
                   int'($urandom_range(512)));
        end
    endtask

    task automatic test_abort();
        int cnt;
        do_reset();
        sample(400, 0, 'h0100, 0, 0);
        @(negedge clk);
        drive(100, 0, 0, 'h0100, 0);
        @(negedge clk);
        bus.rpm_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_integ = 0;
        m_eprev = 0;
        @(negedge clk);
        rst = 1'b0;
        count_valid(cnt);
        vectors++;
        if (cnt != 0 || bus.duty_o !== 16'sd0 || bus.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_rst got %0d/%0d/%b need 0/0/0",
                     cnt, bus.duty_o, bus.busy_o);
        end
        sample(100, 0, 0, 'h0100, 0);
        vectors++;
        if (bus.duty_o !== 16'sd100) begin
            miscompares++;
            $display("FAIL t6_rst_restart got %0d need 100", bus.duty_o);
        end
        @(negedge clk);
        drive(100, 0, 0, 'h0100, 0);
        @(negedge clk);
        bus.rpm_valid_i = 1'b0;
        @(negedge clk);
        bus.pid_en_i = 1'b0;
        m_integ = 0;
        m_eprev = 0;
        @(negedge clk);
        drive(700, 0, 'h0100, 0, 0);
        @(negedge clk);
        bus.rpm_valid_i = 1'b0;
        bus.pid_en_i = 1'b1;
        count_valid(cnt);
        vectors++;
        if (cnt != 0 || bus.duty_o !== 16'sd0 || bus.overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_en got %0d/%0d/%b need 0/0/0",
                     cnt, bus.duty_o, bus.overrun_o);
        end
        sample(100, 0, 0, 'h0100, 0);
        vectors++;
        if (bus.duty_o !== 16'sd100) begin
            miscompares++;
            $display("FAIL t6_en_restart got %0d need 100", bus.duty_o);
        end
    endtask

    initial begin
        test_reset();
        test_prop();
        test_integ();
        test_deriv();
        test_sat();
        test_out_cycle();
        test_overrun();
        test_back_to_back();
        test_abort();
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL pending got %0d need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
